// File: rtl/chess_pkg.sv
// Shared types for the chess board renderer: piece codes,
// board geometry and the standard start position.
package chess_pkg;

  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd7,
    B_KNIGHT = 4'd8,
    B_BISHOP = 4'd9,
    B_ROOK   = 4'd10,
    B_QUEEN  = 4'd11,
    B_KING   = 4'd12
  } piece_t;

  localparam int BOARD_N = 8;
  localparam int NUM_SQ  = BOARD_N * BOARD_N;

  // Index = row*8+col, row 0 is the top (black) rank.
  localparam piece_t START_POS [NUM_SQ] = '{
    B_ROOK, B_KNIGHT, B_BISHOP, B_QUEEN,
    B_KING, B_BISHOP, B_KNIGHT, B_ROOK,
    B_PAWN, B_PAWN, B_PAWN, B_PAWN,
    B_PAWN, B_PAWN, B_PAWN, B_PAWN,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    EMPTY, EMPTY, EMPTY, EMPTY,
    W_PAWN, W_PAWN, W_PAWN, W_PAWN,
    W_PAWN, W_PAWN, W_PAWN, W_PAWN,
    W_ROOK, W_KNIGHT, W_BISHOP, W_QUEEN,
    W_KING, W_BISHOP, W_KNIGHT, W_ROOK
  };

endpackage

// File: rtl/chess_board_regs.sv
// 64-square board register file: one write port, start-position
// load on reset or init_board, one combinational read port.
// Ports: clk, reset_n (sync, active-low), wr_en/wr_sq/wr_piece,
// init_board, rd_sq -> rd_piece.
module chess_board_regs
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [5:0] wr_sq,
  input  logic [3:0] wr_piece,
  input  logic       init_board,
  input  logic [5:0] rd_sq,
  output piece_t     rd_piece
);

  piece_t board [NUM_SQ];

  always_ff @(posedge clk) begin
    if (!reset_n || init_board) begin
      for (int i = 0; i < NUM_SQ; i++) begin
        board[i] <= START_POS[i];
      end
    end else if (wr_en) begin
      board[wr_sq] <= piece_t'(wr_piece);
    end
  end

  // Read sees the pre-write value in a write cycle.
  assign rd_piece = board[rd_sq];

endmodule

// File: rtl/chess_piece_renderer.sv
// Board-wide piece sprite renderer: maps DrawX/DrawY to a square,
// addresses the shared sprite ROM and emits palette index,
// pixel_on, blinking selection highlight and dark-square flag.
// Ports: vga_clk, reset_n (sync, active-low), DrawX/DrawY,
// board write (wr_en/wr_sq/wr_piece), init_board, sel_valid/sel_sq,
// rom_addr -> rom_q (1-cycle sync ROM), pixel_idx, pixel_on,
// hl_on, dark_sq. Output latency is 3 cycles from DrawX/DrawY.
module chess_piece_renderer
  import chess_pkg::*;
#(
  parameter int SPRITE_DIM   = 55,
  parameter int SQUARE_DIM   = 60,
  parameter int BOARD_X0     = 80,
  parameter int BOARD_Y0     = 0,
  parameter int NUM_PIECES   = 12,
  parameter int IDX_W        = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int RA =
    $clog2(NUM_PIECES * SPRITE_DIM * SPRITE_DIM)
)(
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             wr_en,
  input  logic [5:0]       wr_sq,
  input  logic [3:0]       wr_piece,
  input  logic             init_board,
  input  logic             sel_valid,
  input  logic [5:0]       sel_sq,
  output logic [RA-1:0]    rom_addr,
  input  logic [IDX_W-1:0] rom_q,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             pixel_on,
  output logic             hl_on,
  output logic             dark_sq
);

  localparam int INSET   = (SQUARE_DIM - SPRITE_DIM) / 2;
  localparam int BOARD_W = BOARD_N * SQUARE_DIM;
  localparam int SPR_SZ  = SPRITE_DIM * SPRITE_DIM;
  localparam int EDGE    = 2;
  localparam int CW      = $clog2(BLINK_FRAMES);

  logic [10:0]   bx, by;
  logic [10:0]   x_base, y_base;
  logic [10:0]   ox, oy, lx, ly;
  logic [2:0]    col, row;
  logic          on_board, in_spr, occupied;
  logic          border, hl_nxt, dark_nxt;
  piece_t        piece;
  logic [RA-1:0] pm1, addr_nxt;

  logic          s1_vis, s1_hl, s1_dark;
  logic          s2_vis, s2_hl, s2_dark;

  logic          org_q, org_d, frame_tick;
  logic [5:0]    sel_sq_d;
  logic          sel_valid_d, sel_evt;
  logic [CW-1:0] blink_cnt;
  logic          phase_on;

  // Underflow wraps to a large value, which reads as off-board.
  assign bx = {1'b0, DrawX} - 11'(BOARD_X0);
  assign by = {1'b0, DrawY} - 11'(BOARD_Y0);

  assign on_board = (bx < 11'(BOARD_W)) &&
                    (by < 11'(BOARD_W));

  // Comparator chain instead of a divide by SQUARE_DIM.
  always_comb begin
    col    = '0;
    row    = '0;
    x_base = '0;
    y_base = '0;
    for (int k = 1; k < BOARD_N; k++) begin
      if (bx >= 11'(k * SQUARE_DIM)) begin
        col    = 3'(k);
        x_base = 11'(k * SQUARE_DIM);
      end
      if (by >= 11'(k * SQUARE_DIM)) begin
        row    = 3'(k);
        y_base = 11'(k * SQUARE_DIM);
      end
    end
  end

  assign ox = bx - x_base;
  assign oy = by - y_base;
  assign lx = ox - 11'(INSET);
  assign ly = oy - 11'(INSET);

  assign in_spr = on_board &&
    (ox >= 11'(INSET)) && (ox < 11'(INSET + SPRITE_DIM)) &&
    (oy >= 11'(INSET)) && (oy < 11'(INSET + SPRITE_DIM));

  chess_board_regs u_board (
    .clk        (vga_clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_sq      (wr_sq),
    .wr_piece   (wr_piece),
    .init_board (init_board),
    .rd_sq      ({row, col}),
    .rd_piece   (piece)
  );

  assign occupied = (piece != EMPTY);
  assign pm1      = RA'(piece) - RA'(1);

  assign addr_nxt = (in_spr && occupied) ?
    pm1 * RA'(SPR_SZ) + RA'(ly) * RA'(SPRITE_DIM) + RA'(lx) :
    '0;

  assign border = on_board && ({row, col} == sel_sq) &&
    ((ox < 11'(EDGE)) || (ox >= 11'(SQUARE_DIM - EDGE)) ||
     (oy < 11'(EDGE)) || (oy >= 11'(SQUARE_DIM - EDGE)));

  assign hl_nxt   = sel_valid && border && phase_on;
  assign dark_nxt = on_board && (row[0] ^ col[0]);

  // One tick per frame: rising edge of registered (0,0).
  assign frame_tick = org_q && !org_d;
  assign sel_evt    = (sel_sq != sel_sq_d) ||
                      (sel_valid && !sel_valid_d);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      org_q       <= 1'b0;
      org_d       <= 1'b0;
      sel_sq_d    <= '0;
      sel_valid_d <= 1'b0;
      blink_cnt   <= '0;
      phase_on    <= 1'b1;
    end else begin
      org_q       <= (DrawX == 10'd0) && (DrawY == 10'd0);
      org_d       <= org_q;
      sel_sq_d    <= sel_sq;
      sel_valid_d <= sel_valid;
      if (sel_evt) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase_on  <= !phase_on;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      s1_vis    <= 1'b0;
      s1_hl     <= 1'b0;
      s1_dark   <= 1'b0;
      s2_vis    <= 1'b0;
      s2_hl     <= 1'b0;
      s2_dark   <= 1'b0;
      pixel_idx <= '0;
      pixel_on  <= 1'b0;
      hl_on     <= 1'b0;
      dark_sq   <= 1'b0;
    end else begin
      rom_addr  <= addr_nxt;
      s1_vis    <= in_spr && occupied;
      s1_hl     <= hl_nxt;
      s1_dark   <= dark_nxt;
      s2_vis    <= s1_vis;
      s2_hl     <= s1_hl;
      s2_dark   <= s1_dark;
      if (s2_vis && (rom_q != IDX_W'(TRANSP_IDX))) begin
        pixel_on  <= 1'b1;
        pixel_idx <= rom_q;
      end else begin
        pixel_on  <= 1'b0;
        pixel_idx <= '0;
      end
      hl_on     <= s2_hl;
      dark_sq   <= s2_dark;
    end
  end

endmodule

// File: tb/tb_chess_piece_renderer.sv
// Self-checking bench for chess_piece_renderer: directed steps plus
// a randomized pixel stream against a geometric reference model.
module tb_chess_piece_renderer;

  localparam int N = 400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  dx, dy;
  logic        wr_en;
  logic [5:0]  wr_sq;
  logic [3:0]  wr_piece;
  logic        init_board;
  logic        sel_valid;
  logic [5:0]  sel_sq;
  logic [15:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pixel_idx;
  logic        pixel_on, hl_on, dark_sq;

  logic        stub_en;
  logic [3:0]  stub_val;
  logic        ph_on;
  int          bd [64];
  int          n_cmp = 0;
  int          n_bad = 0;

  int          ea [N];
  logic [3:0]  ei [N];
  logic        eo [N], eh [N], ed [N];

  always #5 clk = ~clk;

  chess_piece_renderer dut (
    .vga_clk    (clk),
    .reset_n    (reset_n),
    .DrawX      (dx),
    .DrawY      (dy),
    .wr_en      (wr_en),
    .wr_sq      (wr_sq),
    .wr_piece   (wr_piece),
    .init_board (init_board),
    .sel_valid  (sel_valid),
    .sel_sq     (sel_sq),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pixel_idx  (pixel_idx),
    .pixel_on   (pixel_on),
    .hl_on      (hl_on),
    .dark_sq    (dark_sq)
  );

  function automatic logic [3:0] rom_f(input int a);
    return 4'((a * 7 + 3) % 16);
  endfunction

  always_ff @(posedge clk)
    rom_q <= stub_en ? stub_val : rom_f(int'(rom_addr));

  task automatic load_start();
    int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int s = 0; s < 64; s++) bd[s] = 0;
    for (int c = 0; c < 8; c++) begin
      bd[c]      = back[c] + 6;
      bd[8 + c]  = 7;
      bd[48 + c] = 1;
      bd[56 + c] = back[c];
    end
  endtask

  task automatic model(input int x, input int y,
                       output int addr, output logic [3:0] idx,
                       output logic on, output logic hl,
                       output logic dk);
    int bx, by, col, row, ox, oy, lx, ly, p;
    logic [3:0] q;
    bx = x - 80;
    by = y;
    addr = 0; idx = 0; on = 0; hl = 0; dk = 0;
    if (bx >= 0 && bx < 480 && by >= 0 && by < 480) begin
      col = bx / 60; row = by / 60;
      ox = bx % 60; oy = by % 60;
      lx = ox - 2; ly = oy - 2;
      p = bd[row * 8 + col];
      dk = ((row + col) % 2) == 1;
      hl = sel_valid && (row * 8 + col == int'(sel_sq)) &&
           (ox < 2 || ox > 57 || oy < 2 || oy > 57) && ph_on;
      if (lx >= 0 && lx < 55 && ly >= 0 && ly < 55 && p != 0) begin
        addr = (p - 1) * 3025 + ly * 55 + lx;
        q = stub_en ? stub_val : rom_f(addr);
        on = (q != 0);
        idx = on ? q : 4'd0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input int x, input int y);
    dx = 10'(x);
    dy = 10'(y);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int x, input int y);
    int a; logic [3:0] i; logic o, h, d;
    model(x, y, a, i, o, h, d);
    chk({tag, "_addr"}, 32'(rom_addr), 32'(a));
    chk({tag, "_on"}, 32'(pixel_on), 32'(o));
    chk({tag, "_idx"}, 32'(pixel_idx), 32'(i));
    chk({tag, "_hl"}, 32'(hl_on), 32'(h));
    chk({tag, "_dark"}, 32'(dark_sq), 32'(d));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_on"}, 32'(pixel_on), 0);
    chk({tag, "_idx"}, 32'(pixel_idx), 0);
    chk({tag, "_hl"}, 32'(hl_on), 0);
    chk({tag, "_dark"}, 32'(dark_sq), 0);
  endtask

  initial begin
    int x, y, a;
    logic [3:0] i;
    logic o, h, d;

    reset_n = 0; dx = 10'd349; dy = 10'd449;
    wr_en = 0; wr_sq = 0; wr_piece = 0; init_board = 0;
    sel_valid = 0; sel_sq = 0; stub_en = 0; stub_val = 0;
    ph_on = 1;
    load_start();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1;

    settle(349, 449);
    chk("king_addr", 32'(rom_addr), 16637);
    check_all("king", 349, 449);

    stub_en = 1; stub_val = 0;
    settle(109, 389);
    chk("transp_on", 32'(pixel_on), 0);
    chk("transp_idx", 32'(pixel_idx), 0);
    stub_val = 5;
    settle(109, 389);
    chk("stub5_on", 32'(pixel_on), 1);
    chk("stub5_idx", 32'(pixel_idx), 5);
    stub_en = 0;

    settle(79, 100);
    check_all("off_x", 79, 100);
    settle(200, 480);
    check_all("off_y", 200, 480);
    settle(109, 29);
    chk("dark_c0r0", 32'(dark_sq), 0);
    settle(169, 29);
    chk("dark_c1r0", 32'(dark_sq), 1);

    settle(81, 29);
    chk("inset_m1", 32'(rom_addr), 0);
    settle(136, 29);
    chk("inset_last", 32'(rom_addr), 28764);
    check_all("inset_last", 136, 29);

    settle(289, 269);
    wr_en = 1; wr_sq = 6'd35; wr_piece = 4'd11;
    @(posedge clk); #1;
    wr_en = 0;
    chk("wr_old", 32'(rom_addr), 0);
    @(posedge clk); #1;
    chk("wr_new", 32'(rom_addr), 31762);
    bd[35] = 11;

    wr_en = 1; init_board = 1; wr_sq = 6'd60; wr_piece = 4'd0;
    @(posedge clk); #1;
    wr_en = 0; init_board = 0;
    load_start();
    settle(349, 449);
    chk("init_win", 32'(rom_addr), 16637);
    settle(289, 269);
    check_all("init_sq35", 289, 269);

    sel_valid = 1;
    sel_sq = 6'($urandom_range(0, 63));
    settle(300, 300);
    for (int k = 0; k < N + 3; k++) begin
      if (k >= 1 && k <= N)
        chk("s_addr", 32'(rom_addr), 32'(ea[k - 1]));
      if (k >= 3) begin
        chk("s_on", 32'(pixel_on), 32'(eo[k - 3]));
        chk("s_idx", 32'(pixel_idx), 32'(ei[k - 3]));
        chk("s_hl", 32'(hl_on), 32'(eh[k - 3]));
        chk("s_dark", 32'(dark_sq), 32'(ed[k - 3]));
      end
      if (k < N) begin
        if ($urandom_range(0, 3) == 0) begin
          x = $urandom_range(1, 700);
          y = $urandom_range(0, 520);
        end else begin
          x = 80 + int'(sel_sq % 8) * 60 + $urandom_range(0, 59);
          y = int'(sel_sq / 8) * 60 + $urandom_range(0, 59);
          if ($urandom_range(0, 1) == 1) begin
            x = $urandom_range(80, 559);
            y = $urandom_range(0, 479);
          end
        end
        dx = 10'(x);
        dy = 10'(y);
        model(x, y, ea[k], ei[k], eo[k], eh[k], ed[k]);
        if ($urandom_range(0, 7) == 0) begin
          wr_en = 1;
          wr_sq = 6'($urandom_range(0, 63));
          wr_piece = 4'($urandom_range(0, 12));
          bd[wr_sq] = int'(wr_piece);
        end else begin
          wr_en = 0;
        end
      end else begin
        wr_en = 0;
        dx = 10'd5;
        dy = 10'd5;
      end
      @(posedge clk); #1;
    end

    sel_valid = 0;
    reset_n = 0; dx = 10'd349; dy = 10'd449;
    repeat (2) @(posedge clk);
    #1;
    check_zero("midrst");
    load_start();
    ph_on = 1;
    reset_n = 1;
    @(posedge clk); #1;
    chk("rel1_on", 32'(pixel_on), 0);
    chk("rel1_dark", 32'(dark_sq), 0);
    @(posedge clk); #1;
    chk("rel2_on", 32'(pixel_on), 0);
    chk("rel2_dark", 32'(dark_sq), 0);
    @(posedge clk); #1;
    model(349, 449, a, i, o, h, d);
    chk("rel3_on", 32'(pixel_on), 32'(o));
    chk("rel3_idx", 32'(pixel_idx), 32'(i));
    chk("rel3_dark", 32'(dark_sq), 32'(d));

    sel_valid = 1; sel_sq = 6'd0; ph_on = 1;
    settle(80, 0);
    chk("blink_0", 32'(hl_on), 1);
    for (int k = 1; k <= 95; k++) begin
      dx = 10'd0; dy = 10'd0;
      @(posedge clk); #1;
      ph_on = ((k / 30) % 2) == 0;
      settle(80, 0);
      model(80, 0, a, i, o, h, d);
      chk("blink", 32'(hl_on), 32'(h));
    end
    chk("blink_off95", 32'(hl_on), 0);
    sel_sq = 6'd9;
    ph_on = 1;
    settle(140, 60);
    chk("sel_change", 32'(hl_on), 1);
    check_all("sel_change", 140, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
